seg7_counter_mux: RTL
=====================

// Module: seg7_counter_mux
// PURPOSE
//  Parametrised up/down counter that drives a time-multiplexed NUM_DIGITS seven-segment display.
//  Counter has programmable rate, direction, enable and load, and raises a wrap indication.
//  It also toggles a status LED on each wrap and scans one digit at a time with inter-digit blanking.
//  Sits at board top level between the generated clock domain and the 7-seg/LED pins.
// PARAMETERS
//  NUM_DIGITS  4           digits displayed; count width CW = 4*NUM_DIGITS
//  COUNT_DIV   10_000_000  clk cycles per count tick (>=2)
//  SCAN_DIV    100_000     clk cycles each digit is selected, blank cycle included (>=2)
// PORTS
//  clk               in   1           single clock; all state on rising edge
//  i_reset_n         in   1           asynchronous, active-low reset
//  i_enable          in   1           1: prescaler runs and ticks advance count; 0: prescaler holds
//  i_up_down         in   1           1: count up, 0: count down (sampled on tick)
//  i_load            in   1           synchronous load strobe
//  i_load_value      in   CW          value loaded on i_load
//  o_count           out  CW          current count (registered)
//  o_wrap            out  1           one-cycle pulse, coincident with the wrapped o_count
//  o_led             out  1           toggles on every wrap
//  o_segment_enable  out  [0:6]       segments a..g, active-low (0 = lit)
//  o_display_enable  out  [0:ND-1]    digit selects, active-low; [0] = least-significant nibble
//  o_dot_enable      out  1           decimal point, active-low
// BEHAVIOUR
//  Reset (async, i_reset_n=0): o_count=0, prescaler=0, scan index=0, scan counter=0, o_wrap=0,
//   o_led=0, o_segment_enable='1, o_display_enable='1, o_dot_enable=1. All outputs are registered.
//  Prescaler: 0..COUNT_DIV-1 while i_enable=1. Tick = prescaler at COUNT_DIV-1 and i_enable=1;
//   prescaler then returns to 0. i_enable=0 freezes the prescaler; ticks resume from the held value.
//  Priority per cycle: i_load > tick. i_load: o_count<=i_load_value and prescaler<=0, with no wrap
//   and no tick. The first tick after a load is COUNT_DIV cycles later.
//  Tick: up = +1 and MAX->0; down = -1 and 0->MAX. MAX = 2**CW-1 in binary mode.
//   On a wrap: o_wrap=1 in the same cycle o_count shows the wrapped value, and o_led inverts.
//  Scan: scan counter runs 0..SCAN_DIV-1 regardless of i_enable.
//   At SCAN_DIV-1, index <= (index==NUM_DIGITS-1) ? 0 : index+1.
//   The first cycle of each index is blank: o_display_enable='1.
//   The remaining SCAN_DIV-1 cycles assert o_display_enable[index]=0 only.
//  Segments: registered decode of nibble[index] of o_count (one cycle behind count/index).
//   Hex glyphs: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111
//   8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
//  Dot: o_dot_enable=0 only while digit 0 is selected and i_enable=0 (paused indicator); else 1.
//  Mid-operation reset clears everything immediately. Counting resumes the first tick after release.
// CONFIGURATION
//  COUNTER_BCD_EN defined: each nibble counts 0..9 in decimal with carry/borrow.
//   MAX = all nibbles 9; down from 0 wraps to all 9s.
//   Load clamps any nibble >9 to 9. Glyphs A-F are unreachable.
//  COUNTER_BCD_EN undefined: plain binary CW-bit counter with full hex glyphs.
// STRUCTURE
//  Package seg7_pkg: seg_t (logic [0:6]), SEG_BLANK='1, glyph constant table SEG_GLYPH[16],
//   function digit_to_seg(logic [3:0]).
//  Sub-module seg7_scan: scan counter, digit index, blank cycle, and decode register.
//   Inputs are the count; outputs are segment, display and dot.
//   The top holds the prescaler, counter/BCD logic, wrap and LED.
// TESTING  (NUM_DIGITS=4, COUNT_DIV=4, SCAN_DIV=3)
//  1 Reset: i_reset_n=0 mid-count -> same cycle o_count=0, o_led=0, all enables=1. After release, first tick 4 cycles later gives 0x0001.
//  2 Up wrap: load 0xFFFE, up, enable -> 0xFFFF after 4 cycles, 0x0000 after 8 with o_wrap=1 for 1 cycle, o_led 0->1.
//  3 Down wrap + pause: load 0x0000, down -> 0xFFFF with o_wrap and o_led toggle. Drop i_enable 2 cycles -> count holds; tick arrives 2 cycles late.
//  4 Load vs tick: assert i_load=0x1234 on the tick cycle -> o_count=0x1234, no increment, next tick 4 cycles later gives 0x1235.
//  5 Scan: count=0x12A0 -> digits 0..3 show 0000001, 0001000, 0010010, 1001111. Each digit: 1 blank cycle then 2 active cycles, repeating every 12 cycles.
//  6 BCD (COUNTER_BCD_EN): load 0x0999, up 1 tick -> 0x1000. Load 0x00AF -> 0x0099. Down from 0x0000 -> 0x9999 with o_wrap.

Source files
------------

// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
//   Shared types and constants for the seven-segment counter display.
//
//   seg_t         : segment vector, index 0..6 = segments a..g, active-low
//   SEG_BLANK     : all segments dark
//   SEG_GLYPH     : hex glyph table, entry n = segment pattern for digit n
//   digit_to_seg  : nibble -> active-low segment pattern
//   dir_e         : count direction as presented on i_up_down
// ---------------------------------------------------------------------------
package seg7_pkg;

  typedef logic [0:6] seg_t;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam seg_t SEG_BLANK = '1;

  // Patterns are written a..g left to right; a 0 lights the segment.
  localparam seg_t SEG_GLYPH [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  function automatic seg_t digit_to_seg(input logic [3:0] digit);
    return SEG_GLYPH[digit];
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// ---------------------------------------------------------------------------
// seg7_scan
//   Time-multiplexed digit scanner for a NUM_DIGITS seven-segment display.
//   Each digit is held for SCAN_DIV cycles; the first of those cycles is a
//   blanking cycle (no digit selected) to avoid ghosting between digits.
//   All outputs are registered and therefore trail the scan state and the
//   count by one clock; segment, digit select and dot stay aligned with
//   each other because they are all registered from the same state.
//
//   Ports
//     clk               in   clock, rising edge
//     i_reset_n         in   asynchronous active-low reset
//     i_count           in   [CW-1:0] value to display, nibble 0 = digit 0
//     i_enable          in   counter run enable (for the paused indicator)
//     o_segment_enable  out  [0:6] segments a..g, active-low
//     o_display_enable  out  [0:NUM_DIGITS-1] digit selects, active-low
//     o_dot_enable      out  decimal point, active-low (lit on digit 0
//                            while the counter is paused)
// ---------------------------------------------------------------------------
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100_000,
  localparam int CW        = 4 * NUM_DIGITS
) (
  input  logic                    clk,
  input  logic                    i_reset_n,
  input  logic [CW-1:0]           i_count,
  input  logic                    i_enable,
  output logic [0:6]              o_segment_enable,
  output logic [0:NUM_DIGITS-1]   o_display_enable,
  output logic                    o_dot_enable
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [SW-1:0]         scan_cnt_reg;
  logic [IW-1:0]         idx_reg;
  seg_t                  seg_reg;
  seg_t                  seg_next;
  logic [0:NUM_DIGITS-1] disp_reg;
  logic [0:NUM_DIGITS-1] disp_next;
  logic                  dot_reg;
  logic                  dot_next;
  logic                  digit_active;
  logic [3:0]            nibbles [NUM_DIGITS];

  // Scan position 0 of every digit is the blanking slot.
  assign digit_active = (scan_cnt_reg != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nibbles[gi]   = i_count[4*gi +: 4];
      assign disp_next[gi] = ~(digit_active && (idx_reg == IW'(gi)));
    end
  endgenerate

  assign seg_next = digit_to_seg(nibbles[idx_reg]);
  assign dot_next = ~(digit_active && (idx_reg == '0) && !i_enable);

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      scan_cnt_reg <= '0;
      idx_reg      <= '0;
      seg_reg      <= SEG_BLANK;
      disp_reg     <= '1;
      dot_reg      <= 1'b1;
    end else begin
      if (scan_cnt_reg == SW'(SCAN_DIV - 1)) begin
        scan_cnt_reg <= '0;
        idx_reg      <= (idx_reg == IW'(NUM_DIGITS - 1)) ? '0 : idx_reg + IW'(1);
      end else begin
        scan_cnt_reg <= scan_cnt_reg + SW'(1);
      end
      seg_reg  <= seg_next;
      disp_reg <= disp_next;
      dot_reg  <= dot_next;
    end
  end

  assign o_segment_enable = seg_reg;
  assign o_display_enable = disp_reg;
  assign o_dot_enable     = dot_reg;

endmodule

// File: rtl/seg7_counter_mux.sv
// ---------------------------------------------------------------------------
// seg7_counter_mux
//   Up/down counter with programmable tick rate, shown on a multiplexed
//   NUM_DIGITS seven-segment display. A wrap pulses o_wrap and toggles o_led.
//
//   Build option: define COUNTER_BCD_EN to make every nibble a decimal digit
//   (0..9 with carry/borrow, loads clamped to 9 per nibble). Without it the
//   counter is a plain CW-bit binary counter shown in hex.
//
//   Parameters
//     NUM_DIGITS  digits shown; count width CW = 4*NUM_DIGITS
//     COUNT_DIV   clk cycles per count tick (>=2)
//     SCAN_DIV    clk cycles per digit including its blank cycle (>=2)
//
//   Ports
//     clk               in   clock, rising edge
//     i_reset_n         in   asynchronous active-low reset
//     i_enable          in   1: prescaler runs, ticks advance the count
//     i_up_down         in   1: count up, 0: count down (used on the tick)
//     i_load            in   synchronous load strobe, wins over a tick
//     i_load_value      in   [CW-1:0] value taken on i_load
//     o_count           out  [CW-1:0] current count
//     o_wrap            out  one-cycle pulse together with the wrapped count
//     o_led             out  toggles on every wrap
//     o_segment_enable  out  [0:6] segments a..g, active-low
//     o_display_enable  out  [0:NUM_DIGITS-1] digit selects, active-low
//     o_dot_enable      out  decimal point, active-low
// ---------------------------------------------------------------------------
module seg7_counter_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int COUNT_DIV  = 10_000_000,
  parameter int SCAN_DIV   = 100_000,
  localparam int CW        = 4 * NUM_DIGITS
) (
  input  logic                  clk,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic                  i_up_down,
  input  logic                  i_load,
  input  logic [CW-1:0]         i_load_value,
  output logic [CW-1:0]         o_count,
  output logic                  o_wrap,
  output logic                  o_led,
  output logic [0:6]            o_segment_enable,
  output logic [0:NUM_DIGITS-1] o_display_enable,
  output logic                  o_dot_enable
);

  localparam int PW = $clog2(COUNT_DIV);

  logic [PW-1:0] presc_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [CW-1:0] load_clamped;
  logic          wrap_reg;
  logic          wrap_next;
  logic          led_reg;
  logic          tick;
  dir_e          dir;

  assign dir  = dir_e'(i_up_down);
  // The prescaler only advances while enabled, so a tick needs both.
  assign tick = i_enable && (presc_reg == PW'(COUNT_DIV - 1));

`ifdef COUNTER_BCD_EN
  // carry[i]/borrow[i]: nibble i steps this tick. Built in one process so
  // the ripple chain is a single combinational block.
  logic [NUM_DIGITS:0] carry;
  logic [NUM_DIGITS:0] borrow;

  always_comb begin
    carry     = '0;
    borrow    = '0;
    carry[0]  = 1'b1;
    borrow[0] = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      carry[i+1]  = carry[i]  && (count_reg[4*i +: 4] == 4'd9);
      borrow[i+1] = borrow[i] && (count_reg[4*i +: 4] == 4'd0);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_bcd_digit
      logic [3:0] nib;
      logic [3:0] nib_next;
      logic [3:0] load_nib;

      assign nib      = count_reg[4*gi +: 4];
      assign load_nib = i_load_value[4*gi +: 4];

      always_comb begin
        nib_next = nib;
        if (dir == DIR_UP) begin
          if (carry[gi]) begin
            nib_next = (nib >= 4'd9) ? 4'd0 : nib + 4'd1;
          end
        end else if (borrow[gi]) begin
          nib_next = (nib == 4'd0) ? 4'd9 : nib - 4'd1;
        end
      end

      assign count_next[4*gi +: 4]   = nib_next;
      // Out-of-range load nibbles are forced to 9 so the count stays BCD.
      assign load_clamped[4*gi +: 4] = (load_nib > 4'd9) ? 4'd9 : load_nib;
    end
  endgenerate

  // A carry/borrow out of the top digit is the wrap (all 9s <-> all 0s).
  assign wrap_next = (dir == DIR_UP) ? carry[NUM_DIGITS] : borrow[NUM_DIGITS];
`else
  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    if (dir == DIR_UP) begin
      count_next = count_reg + CW'(1);
      wrap_next  = &count_reg;
    end else begin
      count_next = count_reg - CW'(1);
      wrap_next  = ~|count_reg;
    end
  end

  assign load_clamped = i_load_value;
`endif

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc_reg <= '0;
      count_reg <= '0;
      wrap_reg  <= 1'b0;
      led_reg   <= 1'b0;
    end else if (i_load) begin
      // Load restarts the prescaler so the next tick is a full period away.
      count_reg <= load_clamped;
      presc_reg <= '0;
      wrap_reg  <= 1'b0;
    end else if (tick) begin
      count_reg <= count_next;
      presc_reg <= '0;
      wrap_reg  <= wrap_next;
      if (wrap_next) begin
        led_reg <= ~led_reg;
      end
    end else begin
      wrap_reg <= 1'b0;
      if (i_enable) begin
        presc_reg <= presc_reg + PW'(1);
      end
    end
  end

  assign o_count = count_reg;
  assign o_wrap  = wrap_reg;
  assign o_led   = led_reg;

  seg7_scan #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_scan (
    .clk              (clk),
    .i_reset_n        (i_reset_n),
    .i_count          (count_reg),
    .i_enable         (i_enable),
    .o_segment_enable (o_segment_enable),
    .o_display_enable (o_display_enable),
    .o_dot_enable     (o_dot_enable)
  );

endmodule
